// File: rtl/memp_pkg.sv
`default_nettype none
// ============================================================================
// memp_pkg : shared encodings, head FSM states and buffer entry type for the
//            mem-prepare stage.            Revision 1.0
// ============================================================================
package memp_pkg;

  localparam logic [2:0] CTRL_NONE = 3'd0;
  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LH  = 3'd2;
  localparam logic [2:0] LW  = 3'd3;
  localparam logic [2:0] LD  = 3'd4;
  localparam logic [2:0] LBU = 3'd5;
  localparam logic [2:0] LHU = 3'd6;
  localparam logic [2:0] LWU = 3'd7;
  localparam logic [2:0] SB  = 3'd1;
  localparam logic [2:0] SH  = 3'd2;
  localparam logic [2:0] SW  = 3'd3;
  localparam logic [2:0] SD  = 3'd4;

  typedef enum logic [0:0] {
    HS_REQ  = 1'b0,
    HS_DONE = 1'b1
  } head_state_t;

  // Width-independent per-op control; XLEN-wide payload lives beside it in the top.
  typedef struct packed {
    logic [2:0] rd_ctrl;
    logic [2:0] wr_ctrl;
    logic       rf_wr_en;
    logic [1:0] rf_wr_sel;
    logic [4:0] rd;
    logic       misalign;
    logic       fault;
  } entry_t;

  function automatic logic [3:0] size_of(input logic [2:0] ctrl);
    case (ctrl)
      LB, LBU: size_of = 4'd1;
      LH, LHU: size_of = 4'd2;
      LW, LWU: size_of = 4'd4;
      LD:      size_of = 4'd8;
      default: size_of = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memp_region_decode.sv
`default_nettype none
// ============================================================================
// memp_region_decode : region select, alignment/fault checks, byte strobes
//                      and lane-shifted store data for one op. Revision 1.0
// ============================================================================
module memp_region_decode
  import memp_pkg::*;
#(
  parameter int                        XLEN     = 64,
  parameter int                        NUM_TGT  = 2,
  parameter logic [NUM_TGT*XLEN-1:0]   TGT_BASE = '0,
  parameter logic [NUM_TGT*XLEN-1:0]   TGT_MASK = '0
) (
  input  logic [XLEN-1:0]    addr,
  input  logic [2:0]         rd_ctrl,
  input  logic [2:0]         wr_ctrl,
  input  logic [XLEN-1:0]    wdata_in,
  output logic [NUM_TGT-1:0] sel,
  output logic               misalign,
  output logic               fault,
  output logic [XLEN/8-1:0]  wstrb,
  output logic [XLEN-1:0]    wdata_out
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic               is_st;
  logic               is_mem;
  logic [2:0]         ctrl;
  logic [3:0]         size;
  logic [OFFW-1:0]    off;
  logic [NB-1:0]      lane_mask;
  logic [2*NB-1:0]    strb_wide;
  logic               hit;
  logic [NUM_TGT-1:0] sel_raw;

  always_comb begin
    is_st  = |wr_ctrl;
    is_mem = is_st | (|rd_ctrl);
    // An op carrying both controls is handled as a store.
    ctrl   = is_st ? wr_ctrl : rd_ctrl;
    size   = size_of(ctrl);
    off    = addr[OFFW-1:0];

    misalign = is_mem && ((addr[3:0] & (size - 4'd1)) != 4'd0);

    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < int'(size));
    end
    strb_wide = {{NB{1'b0}}, lane_mask} << off;
    wstrb     = is_st ? strb_wide[NB-1:0] : '0;
    wdata_out = wdata_in << {off, 3'b000};

    // Descending scan so the lowest matching window is the one kept.
    hit     = 1'b0;
    sel_raw = '0;
    for (int t = NUM_TGT - 1; t >= 0; t--) begin
      if ((addr & TGT_MASK[t*XLEN +: XLEN]) == TGT_BASE[t*XLEN +: XLEN]) begin
        hit        = 1'b1;
        sel_raw    = '0;
        sel_raw[t] = 1'b1;
      end
    end

    fault = is_mem && !hit;
    sel   = (is_mem && !misalign && hit) ? sel_raw : '0;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_memp_stage_mc.sv
`default_nettype none
// ============================================================================
// pipeline_memp_stage_mc : EXA->MEMD mem-prepare stage with op buffer and
//                          per-op target request handshake. Revision 1.0
// ============================================================================
module pipeline_memp_stage_mc
  import memp_pkg::*;
#(
  parameter int                      XLEN     = 64,
  parameter int                      NUM_TGT  = 2,
  parameter int                      DEPTH    = 2,
  parameter logic [NUM_TGT*XLEN-1:0] TGT_BASE = {64'h0000_0000_8000_0000, 64'h0},
  parameter logic [NUM_TGT*XLEN-1:0] TGT_MASK = {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_0000}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc_in,
  input  logic                rf_wr_en_in,
  input  logic [1:0]          rf_wr_sel_in,
  input  logic [XLEN-1:0]     addr_in,
  input  logic [2:0]          dm_rd_ctrl_in,
  input  logic [2:0]          dm_wr_ctrl_in,
  input  logic [XLEN-1:0]     wdata_in,
  input  logic [4:0]          rd_in,
  output logic [NUM_TGT-1:0]  tgt_req_valid,
  input  logic [NUM_TGT-1:0]  tgt_req_ready,
  output logic [XLEN-1:0]     tgt_addr,
  output logic [XLEN-1:0]     tgt_wdata,
  output logic [XLEN/8-1:0]   tgt_wstrb,
  output logic [2:0]          tgt_rd_ctrl,
  output logic [2:0]          tgt_wr_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pc_out,
  output logic                rf_wr_en_out,
  output logic [1:0]          rf_wr_sel_out,
  output logic [4:0]          rd_out,
  output logic [XLEN-1:0]     alu_result_out,
  output logic [NUM_TGT-1:0]  tgt_sel_out,
  output logic                misalign_out,
  output logic                access_fault_out
);

  localparam int NB = XLEN / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t [DEPTH-1:0]                ent_q,   ent_d;
  logic   [DEPTH-1:0][XLEN-1:0]      pc_q,    pc_d;
  logic   [DEPTH-1:0][XLEN-1:0]      addr_q,  addr_d;
  logic   [DEPTH-1:0][XLEN-1:0]      wdata_q, wdata_d;
  logic   [DEPTH-1:0][NB-1:0]        wstrb_q, wstrb_d;
  logic   [DEPTH-1:0][NUM_TGT-1:0]   sel_q,   sel_d;
  logic   [PW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic   [PW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic   [CW-1:0]                   count_q,  count_d;
  head_state_t                       state_q,  state_d;

  logic [NUM_TGT-1:0] dec_sel;
  logic               dec_misalign;
  logic               dec_fault;
  logic [NB-1:0]      dec_wstrb;
  logic [XLEN-1:0]    dec_wdata;
  entry_t             new_ent;
  entry_t             head;
  logic [NUM_TGT-1:0] head_sel;
  logic               empty, full, push, pop, req_fire;

  memp_region_decode #(
    .XLEN     (XLEN),
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr      (addr_in),
    .rd_ctrl   (dm_rd_ctrl_in),
    .wr_ctrl   (dm_wr_ctrl_in),
    .wdata_in  (wdata_in),
    .sel       (dec_sel),
    .misalign  (dec_misalign),
    .fault     (dec_fault),
    .wstrb     (dec_wstrb),
    .wdata_out (dec_wdata)
  );

  always_comb begin
    new_ent.rd_ctrl   = dm_rd_ctrl_in;
    new_ent.wr_ctrl   = dm_wr_ctrl_in;
    new_ent.rf_wr_en  = rf_wr_en_in;
    new_ent.rf_wr_sel = rf_wr_sel_in;
    new_ent.rd        = rd_in;
    new_ent.misalign  = dec_misalign;
    new_ent.fault     = dec_fault;
  end

  assign head     = ent_q[rd_ptr_q];
  assign head_sel = sel_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  // A head with no target selected (non-mem or faulted) is presented to MEMD at once.
  assign tgt_req_valid = (!empty && state_q == HS_REQ) ? head_sel : '0;
  assign req_fire      = |(tgt_req_valid & tgt_req_ready);
  assign out_valid     = !empty && (state_q == HS_DONE || !(|head_sel));
  assign pop           = out_valid && out_ready;
  assign in_ready      = !full || pop;
  assign push          = in_valid && in_ready && !flush;

  always_comb begin
    ent_d    = ent_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    sel_d    = sel_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    if (push) begin
      ent_d[wr_ptr_q]   = new_ent;
      pc_d[wr_ptr_q]    = pc_in;
      addr_d[wr_ptr_q]  = addr_in;
      wdata_d[wr_ptr_q] = dec_wdata;
      wstrb_d[wr_ptr_q] = dec_wstrb;
      sel_d[wr_ptr_q]   = dec_sel;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (!empty && state_q == HS_REQ && (!(|head_sel) || req_fire)) begin
      state_d = HS_DONE;
    end
    if (pop) begin
      state_d = HS_REQ;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = HS_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q    <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= HS_REQ;
    end else begin
      ent_q    <= ent_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign tgt_addr         = addr_q[rd_ptr_q];
  assign tgt_wdata        = wdata_q[rd_ptr_q];
  assign tgt_wstrb        = wstrb_q[rd_ptr_q];
  assign tgt_rd_ctrl      = head.rd_ctrl;
  assign tgt_wr_ctrl      = head.wr_ctrl;
  assign pc_out           = pc_q[rd_ptr_q];
  assign rf_wr_en_out     = head.rf_wr_en;
  assign rf_wr_sel_out    = head.rf_wr_sel;
  assign rd_out           = head.rd;
  assign alu_result_out   = addr_q[rd_ptr_q];
  assign tgt_sel_out      = head_sel;
  assign misalign_out     = head.misalign;
  assign access_fault_out = head.fault;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_memp_stage_mc.sv
`default_nettype none
// Scoreboard bench for pipeline_memp_stage_mc: expected requests/outputs are
// queued at enqueue and popped by monitors on each DUT handshake.
module tb_pipeline_memp_stage_mc;
  import memp_pkg::*;

  // Overlapping windows so the lowest-index priority is exercised.
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] MASK0 = 64'hFFFF_FFFF_FFFF_0000;
  localparam logic [63:0] BASE1 = 64'h0;
  localparam logic [63:0] MASK1 = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, rf_wr_en_in, out_ready;
  logic [1:0]  rf_wr_sel_in, tgt_req_ready;
  logic [63:0] pc_in, addr_in, wdata_in;
  logic [2:0]  dm_rd_ctrl_in, dm_wr_ctrl_in;
  logic [4:0]  rd_in;
  logic        in_ready, out_valid, rf_wr_en_out, misalign_out, access_fault_out;
  logic [1:0]  tgt_req_valid, rf_wr_sel_out, tgt_sel_out;
  logic [63:0] tgt_addr, tgt_wdata, pc_out, alu_result_out;
  logic [7:0]  tgt_wstrb;
  logic [2:0]  tgt_rd_ctrl, tgt_wr_ctrl;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  pipeline_memp_stage_mc #(
    .XLEN(64), .NUM_TGT(2), .DEPTH(2),
    .TGT_BASE({BASE1, BASE0}), .TGT_MASK({MASK1, MASK0})
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .rf_wr_en_in(rf_wr_en_in), .rf_wr_sel_in(rf_wr_sel_in), .addr_in(addr_in),
    .dm_rd_ctrl_in(dm_rd_ctrl_in), .dm_wr_ctrl_in(dm_wr_ctrl_in), .wdata_in(wdata_in), .rd_in(rd_in),
    .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb), .tgt_rd_ctrl(tgt_rd_ctrl), .tgt_wr_ctrl(tgt_wr_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .rf_wr_en_out(rf_wr_en_out),
    .rf_wr_sel_out(rf_wr_sel_out), .rd_out(rd_out), .alu_result_out(alu_result_out),
    .tgt_sel_out(tgt_sel_out), .misalign_out(misalign_out), .access_fault_out(access_fault_out)
  );

  typedef struct {
    logic [63:0] pc, addr, wdata;
    logic [2:0]  rc, wc;
    logic        we;
    logic [1:0]  ws;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [63:0] pc, alu;
    logic        we;
    logic [1:0]  ws;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        mis, flt;
  } out_exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] addr, wdata;
    logic [7:0]  strb;
    logic [2:0]  rc, wc;
  } req_exp_t;

  out_exp_t out_q[$];
  req_exp_t req_q[$];
  int vectors = 0;
  int miscompares = 0;
  int tgt_mode = 1;   // 0 random, 1 never ready, 2 always ready
  int out_mode = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int region_of(input logic [63:0] a);
    if ((a & MASK0) == BASE0) return 0;
    if ((a & MASK1) == BASE1) return 1;
    return -1;
  endfunction

  task automatic expect_op(input op_t o);
    out_exp_t    oe;
    req_exp_t    re;
    bit          st, mem;
    int          code, size, off, r;
    logic [15:0] sw;
    st   = (o.wc != 0);
    mem  = st || (o.rc != 0);
    code = st ? int'(o.wc) : int'(o.rc);
    size = (code == 1 || code == 5) ? 1 : (code == 2 || code == 6) ? 2 :
           (code == 3 || code == 7) ? 4 : (code == 4) ? 8 : 1;
    off  = int'(o.addr % 8);
    r    = region_of(o.addr);
    oe.pc = o.pc; oe.alu = o.addr; oe.we = o.we; oe.ws = o.ws; oe.rd = o.rd;
    oe.mis = mem && ((o.addr % size) != 0);
    oe.flt = mem && (r < 0);
    oe.sel = '0;
    if (mem && !oe.mis && r >= 0) oe.sel[r] = 1'b1;
    out_q.push_back(oe);
    if (oe.sel != 0) begin
      sw = ((16'd1 << size) - 16'd1) << off;
      re.sel   = oe.sel;
      re.addr  = o.addr;
      re.wdata = o.wdata << (8 * off);
      re.strb  = st ? sw[7:0] : 8'h00;
      re.rc    = o.rc;
      re.wc    = o.wc;
      req_q.push_back(re);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.pc = {$urandom, $urandom}; o.wdata = {$urandom, $urandom};
    o.rd = 5'($urandom); o.we = 1'($urandom); o.ws = 2'($urandom);
    o.rc = 3'd0; o.wc = 3'd0;
    case ($urandom_range(0, 5))
      1, 2: o.rc = 3'($urandom_range(1, 7));
      3, 4: o.wc = 3'($urandom_range(1, 4));
      5: begin o.rc = 3'($urandom_range(1, 7)); o.wc = 3'($urandom_range(1, 4)); end
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: o.addr = {48'h0, 16'($urandom)};
      1: o.addr = {32'h0, 1'b1, 31'($urandom)};
      default: o.addr = {32'($urandom_range(1, 32'hFFFF)), 32'($urandom)};
    endcase
    if ($urandom_range(0, 1) == 1) o.addr[2:0] = 3'b000;
    return o;
  endfunction

  task automatic drive(input op_t o);
    @(posedge clk); #1;
    in_valid = 1'b1; pc_in = o.pc; addr_in = o.addr; wdata_in = o.wdata;
    dm_rd_ctrl_in = o.rc; dm_wr_ctrl_in = o.wc; rf_wr_en_in = o.we;
    rf_wr_sel_in = o.ws; rd_in = o.rd;
  endtask

  task automatic accept(input op_t o);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else expect_op(o);
  endtask

  task automatic send(input op_t o);
    drive(o);
    accept(o);
  endtask

  task automatic idle();
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((out_q.size() != 0 || req_q.size() != 0) && g < 2000) begin @(negedge clk); g++; end
    chk("drain_pending", 64'(out_q.size() + req_q.size()), 0);
  endtask

  // Sink-side ready generators.
  initial begin
    tgt_req_ready = '0; out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tgt_req_ready = (tgt_mode == 0) ? 2'($urandom) : (tgt_mode == 2) ? 2'b11 : 2'b00;
      out_ready     = (out_mode == 0) ? 1'($urandom) : (out_mode == 2);
    end
  end

  // Monitors: pop expectations on each request / output handshake.
  initial begin
    bit          pend_req = 0, pend_out = 0, prev_flush = 0;
    logic [1:0]  pv;
    logic [63:0] pa, pd;
    req_exp_t    re;
    out_exp_t    oe;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_req = 0; pend_out = 0; prev_flush = 0;
      end else begin
        if (pend_req && !prev_flush) begin
          chk("req_hold_valid", tgt_req_valid, pv);
          chk("req_hold_addr", tgt_addr, pa);
          chk("req_hold_wdata", tgt_wdata, pd);
        end
        if (tgt_req_valid != 0) chk("req_onehot", 64'($countones(tgt_req_valid)), 1);
        if ((tgt_req_valid & tgt_req_ready) != 0) begin
          chk("req_expected", 64'(req_q.size() != 0), 1);
          if (req_q.size() != 0) begin
            re = req_q.pop_front();
            chk("req_sel", tgt_req_valid, re.sel);
            chk("req_addr", tgt_addr, re.addr);
            chk("req_wdata", tgt_wdata, re.wdata);
            chk("req_wstrb", tgt_wstrb, re.strb);
            chk("req_ctrl", {tgt_rd_ctrl, tgt_wr_ctrl}, {re.rc, re.wc});
          end
          pend_req = 0;
        end else begin
          pend_req = (tgt_req_valid != 0);
          pv = tgt_req_valid; pa = tgt_addr; pd = tgt_wdata;
        end
        if (pend_out && !prev_flush) chk("out_hold", out_valid, 1);
        if (out_valid && out_ready) begin
          chk("out_expected", 64'(out_q.size() != 0), 1);
          if (out_q.size() != 0) begin
            oe = out_q.pop_front();
            chk("out_pc", pc_out, oe.pc);
            chk("out_alu", alu_result_out, oe.alu);
            chk("out_rf", {rf_wr_en_out, rf_wr_sel_out, rd_out}, {oe.we, oe.ws, oe.rd});
            chk("out_sel", tgt_sel_out, oe.sel);
            chk("out_flags", {misalign_out, access_fault_out}, {oe.mis, oe.flt});
          end
          pend_out = 0;
        end else begin
          pend_out = out_valid;
        end
        prev_flush = flush;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    pc_in = '0; addr_in = '0; wdata_in = '0; dm_rd_ctrl_in = '0; dm_wr_ctrl_in = '0;
    rf_wr_en_in = 1'b0; rf_wr_sel_in = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", tgt_req_valid, 0);
    chk("rst_wstrb", tgt_wstrb, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_sel", tgt_sel_out, 0);
    @(posedge clk); #1 reset = 1'b0;

    // SD to dram, ready held low for three cycles.
    tgt_mode = 1; out_mode = 2;
    o = '{pc:64'h100, addr:64'h8000_0010, wdata:64'h11, rc:3'd0, wc:SD, we:1'b0, ws:2'd0, rd:5'd0};
    send(o); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sd_req_valid", tgt_req_valid, 2'b10);
      chk("sd_wstrb", tgt_wstrb, 8'hFF);
    end
    tgt_mode = 2; drain();

    // SB to sys_bus lane 3 (address also inside the dram window).
    tgt_mode = 1;
    o = '{pc:64'h104, addr:64'h1003, wdata:64'hAB, rc:3'd0, wc:SB, we:1'b0, ws:2'd0, rd:5'd0};
    send(o); idle();
    @(negedge clk);
    chk("sb_req_valid", tgt_req_valid, 2'b01);
    chk("sb_wstrb", tgt_wstrb, 8'h08);
    chk("sb_wdata", tgt_wdata, 64'h0000_0000_AB00_0000);
    tgt_mode = 2; drain();

    // Misaligned LW: no request, op still delivered.
    tgt_mode = 0; out_mode = 1;
    o = '{pc:64'h108, addr:64'h8000_0002, wdata:64'h0, rc:LW, wc:3'd0, we:1'b1, ws:2'd1, rd:5'd7};
    send(o); idle();
    @(negedge clk);
    chk("lw_misalign", misalign_out, 1);
    chk("lw_req_valid", tgt_req_valid, 0);
    chk("lw_out_valid", out_valid, 1);
    chk("lw_pc", pc_out, 64'h108);
    out_mode = 2; drain();

    // Non-mem ADD.
    out_mode = 1;
    o = '{pc:64'h10C, addr:64'h1234, wdata:64'h0, rc:3'd0, wc:3'd0, we:1'b1, ws:2'd0, rd:5'd3};
    send(o); idle();
    @(negedge clk);
    chk("add_out_valid", out_valid, 1);
    chk("add_sel", tgt_sel_out, 0);
    chk("add_alu", alu_result_out, 64'h1234);
    out_mode = 2; drain();

    // Back-to-back into a full buffer.
    out_mode = 1; tgt_mode = 0;
    send(rand_op()); send(rand_op());
    o = rand_op(); drive(o);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    out_mode = 2;
    accept(o); idle();
    tgt_mode = 2; drain();

    // Flush while head waits for target ready; same-cycle enqueue dropped.
    out_mode = 1; tgt_mode = 1;
    o = '{pc:64'h110, addr:64'h8000_0020, wdata:64'h55, rc:3'd0, wc:SW, we:1'b0, ws:2'd0, rd:5'd0};
    send(o); idle();
    @(negedge clk);
    chk("fl_req_valid", tgt_req_valid, 2'b10);
    drive(rand_op()); flush = 1'b1;
    @(negedge clk);
    out_q.delete(); req_q.delete();
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_req_valid_after", tgt_req_valid, 0);
      chk("fl_in_ready", in_ready, 1);
    end

    // Randomised traffic with random backpressure on both sides.
    tgt_mode = 0; out_mode = 0;
    for (int n = 0; n < 300; n++) begin
      send(rand_op());
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    tgt_mode = 2; out_mode = 2;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
